// File: rtl/branch_resolve_unit_if.sv
// Port bundle for the branch resolve unit: EX resolve inputs, redirect/GHSR restore,
// PHT read/write and BTB write channels to the fetch-side predictor, and statistics.
interface branch_resolve_unit_if #(
  parameter int unsigned GHSR_W    = 10,
  parameter int unsigned PHT_IDX_W = 10,
  parameter int unsigned BTB_IDX_W = 9
);
  logic                   ex_valid;
  logic                   ex_is_branch;
  logic                   ex_is_jump;
  logic                   ex_is_jumpr;
  logic [31:0]            ex_pc;
  logic [GHSR_W+33:0]     ex_predict;
  logic                   ex_taken;
  logic [31:0]            ex_target;
  logic                   upd_full;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   ghsr_restore_valid;
  logic [GHSR_W-1:0]      ghsr_restore;
  logic                   pht_gnt;
  logic                   pht_rd_en;
  logic [PHT_IDX_W-1:0]   pht_rd_idx;
  logic [1:0]             pht_rd_data;
  logic                   pht_wr_en;
  logic [PHT_IDX_W-1:0]   pht_wr_idx;
  logic [1:0]             pht_wr_data;
  logic                   btb_wr_en;
  logic [BTB_IDX_W-1:0]   btb_wr_idx;
  logic [29-BTB_IDX_W:0]  btb_wr_tag;
  logic [31:0]            btb_wr_target;
  logic [31:0]            branch_cnt;
  logic [31:0]            mispredict_cnt;

  // Environment side: EX stage plus the predictor owning the PHT/BTB.
  modport master (
    output ex_valid, ex_is_branch, ex_is_jump, ex_is_jumpr, ex_pc, ex_predict, ex_taken,
           ex_target, pht_gnt, pht_rd_data,
    input  upd_full, redirect_valid, redirect_pc, ghsr_restore_valid, ghsr_restore,
           pht_rd_en, pht_rd_idx, pht_wr_en, pht_wr_idx, pht_wr_data, btb_wr_en, btb_wr_idx,
           btb_wr_tag, btb_wr_target, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jump, ex_is_jumpr, ex_pc, ex_predict, ex_taken,
           ex_target, pht_gnt, pht_rd_data,
    output upd_full, redirect_valid, redirect_pc, ghsr_restore_valid, ghsr_restore,
           pht_rd_en, pht_rd_idx, pht_wr_en, pht_wr_idx, pht_wr_data, btb_wr_en, btb_wr_idx,
           btb_wr_tag, btb_wr_target, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: registered redirect/GHSR restore on mispredict, and a queued
// two-stage PHT read-modify-write plus BTB write for predictor training.
module branch_resolve_unit #(
  parameter int unsigned GHSR_W    = 10,
  parameter int unsigned PHT_IDX_W = 10,
  parameter int unsigned BTB_IDX_W = 9,
  parameter int unsigned UPD_DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  branch_resolve_unit_if.slave bru
);
  localparam int unsigned PtrW = $clog2(UPD_DEPTH);

  typedef struct packed {
    logic                 is_branch;
    logic                 taken;
    logic [PHT_IDX_W-1:0] pht_idx;
    logic [29:0]          pc_w;
    logic [31:0]          target;
    logic                 btb_write;
  } upd_t;

  logic                 taken_predict, btb_hit;
  logic [GHSR_W-1:0]    cur_ghsr;
  logic [31:0]          btb_addr;
  logic                 is_jump, taken, target_miss, mispredict, accept, pop;
  upd_t                 push_entry, head;

  upd_t                 mem_q [UPD_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 redirect_valid_q;
  logic [31:0]          redirect_pc_q;
  logic [GHSR_W-1:0]    ghsr_q;
  logic [31:0]          branch_cnt_q, mispredict_cnt_q;
  logic                 u2_valid_q;
  upd_t                 u2_q;
  logic                 last_wr_en_q;
  logic [PHT_IDX_W-1:0] last_wr_idx_q;
  logic [1:0]           last_wr_data_q;
  logic [1:0]           old_ctr, new_ctr;

  assign {taken_predict, cur_ghsr, btb_hit, btb_addr} = bru.ex_predict;

  assign is_jump     = bru.ex_is_jump || bru.ex_is_jumpr;
  assign taken       = bru.ex_is_branch ? bru.ex_taken : is_jump;
  assign target_miss = !btb_hit || (btb_addr != bru.ex_target);
  assign mispredict  = bru.ex_is_branch ?
                       ((bru.ex_taken != taken_predict) || (bru.ex_taken && target_miss)) :
                       (is_jump && target_miss);

  assign bru.upd_full = (count_q == (PtrW + 1)'(UPD_DEPTH));
  assign accept       = bru.ex_valid && !bru.upd_full;
  assign pop          = (count_q != '0) && bru.pht_gnt;

  always_comb begin
    push_entry           = '0;
    push_entry.is_branch = bru.ex_is_branch;
    push_entry.taken     = taken;
    push_entry.pht_idx   = PHT_IDX_W'(cur_ghsr) ^ bru.ex_pc[PHT_IDX_W+1:2];
    push_entry.pc_w      = bru.ex_pc[31:2];
    push_entry.target    = bru.ex_target;
    push_entry.btb_write = taken && target_miss;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      ghsr_q           <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      redirect_valid_q <= accept && mispredict;
      if (accept && mispredict) begin
        redirect_pc_q    <= taken ? bru.ex_target : bru.ex_pc + 32'd4;
        // Jumps do not shift history; branches restore with the real outcome appended.
        ghsr_q           <= bru.ex_is_branch ? {cur_ghsr[GHSR_W-2:0], bru.ex_taken} : cur_ghsr;
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
      if (accept) branch_cnt_q <= branch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u2_valid_q     <= 1'b0;
      u2_q           <= '0;
      last_wr_en_q   <= 1'b0;
      last_wr_idx_q  <= '0;
      last_wr_data_q <= '0;
    end else begin
      u2_valid_q     <= pop;
      if (pop) u2_q  <= head;
      last_wr_en_q   <= bru.pht_wr_en;
      last_wr_idx_q  <= bru.pht_wr_idx;
      last_wr_data_q <= bru.pht_wr_data;
    end
  end

  always_comb begin
    // The PHT read overlapped last cycle's write; forward that write if it hit our index.
    old_ctr = (last_wr_en_q && (last_wr_idx_q == u2_q.pht_idx)) ? last_wr_data_q :
                                                                   bru.pht_rd_data;
    if (u2_q.taken) new_ctr = (old_ctr == 2'd3) ? 2'd3 : old_ctr + 2'd1;
    else            new_ctr = (old_ctr == 2'd0) ? 2'd0 : old_ctr - 2'd1;
  end

  assign bru.redirect_valid     = redirect_valid_q;
  assign bru.redirect_pc        = redirect_pc_q;
  assign bru.ghsr_restore_valid = redirect_valid_q;
  assign bru.ghsr_restore       = ghsr_q;
  assign bru.branch_cnt         = branch_cnt_q;
  assign bru.mispredict_cnt     = mispredict_cnt_q;

  assign bru.pht_rd_en     = pop && head.is_branch;
  assign bru.pht_rd_idx    = bru.pht_rd_en ? head.pht_idx : '0;
  assign bru.pht_wr_en     = u2_valid_q && u2_q.is_branch;
  assign bru.pht_wr_idx    = bru.pht_wr_en ? u2_q.pht_idx : '0;
  assign bru.pht_wr_data   = bru.pht_wr_en ? new_ctr : 2'd0;
  assign bru.btb_wr_en     = u2_valid_q && u2_q.btb_write;
  assign bru.btb_wr_idx    = bru.btb_wr_en ? u2_q.pc_w[BTB_IDX_W-1:0] : '0;
  assign bru.btb_wr_tag    = bru.btb_wr_en ? u2_q.pc_w[29:BTB_IDX_W] : '0;
  assign bru.btb_wr_target = bru.btb_wr_en ? u2_q.target : '0;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: redirect, PHT bypass/saturation, BTB training,
// back-pressure and reset flush, checked with immediate assertions.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  branch_resolve_unit_if #(.GHSR_W(10), .PHT_IDX_W(10), .BTB_IDX_W(9)) bif ();

  branch_resolve_unit #(.GHSR_W(10), .PHT_IDX_W(10), .BTB_IDX_W(9), .UPD_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bru   (bif)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic br, input logic jp, input logic jr, input logic [31:0] pc,
                       input logic tp, input logic [9:0] gh, input logic hit,
                       input logic [31:0] baddr, input logic tk, input logic [31:0] tgt);
    bif.ex_valid     = 1'b1;
    bif.ex_is_branch = br;
    bif.ex_is_jump   = jp;
    bif.ex_is_jumpr  = jr;
    bif.ex_pc        = pc;
    bif.ex_predict   = {tp, gh, hit, baddr};
    bif.ex_taken     = tk;
    bif.ex_target    = tgt;
  endtask

  initial begin
    reset = 1'b1;
    bif.ex_valid = 1'b0;
    bif.ex_is_branch = 1'b0;
    bif.ex_is_jump = 1'b0;
    bif.ex_is_jumpr = 1'b0;
    bif.ex_pc = '0;
    bif.ex_predict = '0;
    bif.ex_taken = 1'b0;
    bif.ex_target = '0;
    bif.pht_gnt = 1'b1;
    bif.pht_rd_data = 2'd0;
    tick();
    tick();
    chk("rst_redirect", 32'(bif.redirect_valid), 32'd0);
    chk("rst_full", 32'(bif.upd_full), 32'd0);
    chk("rst_pht_wr", 32'(bif.pht_wr_en), 32'd0);
    chk("rst_btb_wr", 32'(bif.btb_wr_en), 32'd0);
    chk("rst_bcnt", bif.branch_cnt, 32'd0);
    chk("rst_mcnt", bif.mispredict_cnt, 32'd0);
    reset = 1'b0;
    tick();

    // Mispredicted branch, BTB miss, taken to 0x80.
    drive(1, 0, 0, 32'h100, 0, 10'h3FF, 0, 32'h0, 1, 32'h80);
    tick();
    bif.ex_valid = 1'b0;
    chk("t1_redirect", 32'(bif.redirect_valid), 32'd1);
    chk("t1_redirect_pc", bif.redirect_pc, 32'h80);
    chk("t1_ghsr_valid", 32'(bif.ghsr_restore_valid), 32'd1);
    chk("t1_ghsr", 32'(bif.ghsr_restore), 32'h3FF);
    chk("t1_bcnt", bif.branch_cnt, 32'd1);
    chk("t1_mcnt", bif.mispredict_cnt, 32'd1);
    chk("t1_rd_en", 32'(bif.pht_rd_en), 32'd1);
    chk("t1_rd_idx", 32'(bif.pht_rd_idx), 32'h3BF);
    tick();
    bif.pht_rd_data = 2'd1;
    #1;
    chk("t1_redirect_off", 32'(bif.redirect_valid), 32'd0);
    chk("t1_wr_en", 32'(bif.pht_wr_en), 32'd1);
    chk("t1_wr_idx", 32'(bif.pht_wr_idx), 32'h3BF);
    chk("t1_wr_data", 32'(bif.pht_wr_data), 32'd2);
    chk("t1_btb_en", 32'(bif.btb_wr_en), 32'd1);
    chk("t1_btb_idx", 32'(bif.btb_wr_idx), 32'h40);
    chk("t1_btb_tag", 32'(bif.btb_wr_tag), 32'h0);
    chk("t1_btb_tgt", bif.btb_wr_target, 32'h80);
    tick();

    // Correctly predicted taken branch; counter saturation 2->3, 3->3.
    drive(1, 0, 0, 32'h400, 1, 10'h000, 1, 32'h500, 1, 32'h500);
    tick();
    bif.ex_valid = 1'b0;
    chk("t2_redirect", 32'(bif.redirect_valid), 32'd0);
    chk("t2_mcnt", bif.mispredict_cnt, 32'd1);
    chk("t2_bcnt", bif.branch_cnt, 32'd2);
    tick();
    bif.pht_rd_data = 2'd2;
    #1;
    chk("t2_wr_idx", 32'(bif.pht_wr_idx), 32'h100);
    chk("t2_wr_data", 32'(bif.pht_wr_data), 32'd3);
    chk("t2_btb_en", 32'(bif.btb_wr_en), 32'd0);
    tick();
    tick();
    drive(1, 0, 0, 32'h400, 1, 10'h000, 1, 32'h500, 1, 32'h500);
    tick();
    bif.ex_valid = 1'b0;
    tick();
    bif.pht_rd_data = 2'd3;
    #1;
    chk("t2_sat", 32'(bif.pht_wr_data), 32'd3);
    tick();

    // Back-to-back same index, not taken, stale read data of 1.
    drive(1, 0, 0, 32'h800, 0, 10'h000, 0, 32'h0, 0, 32'h0);
    tick();
    tick();
    bif.ex_valid = 1'b0;
    bif.pht_rd_data = 2'd1;
    #1;
    chk("t3_nt_idx", 32'(bif.pht_wr_idx), 32'h200);
    chk("t3_nt_first", 32'(bif.pht_wr_data), 32'd0);
    tick();
    chk("t3_nt_second", 32'(bif.pht_wr_data), 32'd0);
    tick();
    // Same with taken: bypass must give 1->2->3 rather than 2 twice.
    drive(1, 0, 0, 32'hC00, 1, 10'h000, 1, 32'hC40, 1, 32'hC40);
    tick();
    tick();
    bif.ex_valid = 1'b0;
    chk("t3_tk_first", 32'(bif.pht_wr_data), 32'd2);
    tick();
    chk("t3_tk_idx", 32'(bif.pht_wr_idx), 32'h300);
    chk("t3_tk_bypass", 32'(bif.pht_wr_data), 32'd3);
    tick();
    chk("t3_bcnt", bif.branch_cnt, 32'd7);
    chk("t3_mcnt", bif.mispredict_cnt, 32'd1);

    // JALR with wrong BTB target.
    drive(0, 0, 1, 32'h200, 0, 10'h155, 1, 32'h300, 0, 32'h304);
    tick();
    bif.ex_valid = 1'b0;
    chk("t4_redirect", 32'(bif.redirect_valid), 32'd1);
    chk("t4_redirect_pc", bif.redirect_pc, 32'h304);
    chk("t4_ghsr", 32'(bif.ghsr_restore), 32'h155);
    chk("t4_mcnt", bif.mispredict_cnt, 32'd2);
    chk("t4_rd_en", 32'(bif.pht_rd_en), 32'd0);
    tick();
    chk("t4_pht_wr", 32'(bif.pht_wr_en), 32'd0);
    chk("t4_btb_en", 32'(bif.btb_wr_en), 32'd1);
    chk("t4_btb_idx", 32'(bif.btb_wr_idx), 32'h80);
    chk("t4_btb_tag", 32'(bif.btb_wr_tag), 32'h0);
    chk("t4_btb_tgt", bif.btb_wr_target, 32'h304);
    tick();
    // JAL hitting the right target: no redirect regardless of taken_predict.
    drive(0, 1, 0, 32'h2000, 0, 10'h000, 1, 32'h3000, 0, 32'h3000);
    tick();
    bif.ex_valid = 1'b0;
    chk("t4_jal_redirect", 32'(bif.redirect_valid), 32'd0);
    chk("t4_jal_mcnt", bif.mispredict_cnt, 32'd2);
    tick();
    chk("t4_jal_btb", 32'(bif.btb_wr_en), 32'd0);
    chk("t4_jal_pht", 32'(bif.pht_wr_en), 32'd0);
    tick();

    // Back-pressure: grant withheld, five attempts, only four accepted.
    bif.pht_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 32'h1000 + 32'(4 * i), 0, 10'h000, 0, 32'h0, 0, 32'h0);
      tick();
      if (i == 3) chk("t5_full_at4", 32'(bif.upd_full), 32'd1);
    end
    bif.ex_valid = 1'b0;
    chk("t5_full", 32'(bif.upd_full), 32'd1);
    chk("t5_bcnt", bif.branch_cnt, 32'd13);
    chk("t5_no_rd", 32'(bif.pht_rd_en), 32'd0);
    bif.pht_gnt = 1'b1;
    bif.pht_rd_data = 2'd1;
    #1;
    chk("t5_rd_en", 32'(bif.pht_rd_en), 32'd1);
    chk("t5_rd_idx", 32'(bif.pht_rd_idx), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_wr_en", 32'(bif.pht_wr_en), 32'd1);
      chk("t5_wr_idx", 32'(bif.pht_wr_idx), 32'(k));
      chk("t5_wr_data", 32'(bif.pht_wr_data), 32'd0);
      if (k == 0) chk("t5_full_drop", 32'(bif.upd_full), 32'd0);
    end
    tick();
    chk("t5_fifth_dropped", 32'(bif.pht_wr_en), 32'd0);

    // Reset with queued entries and one update in flight.
    bif.pht_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 32'h40 + 32'(4 * i), 1, 10'h000, 0, 32'h0, 1, 32'h900);
      tick();
    end
    bif.ex_valid = 1'b0;
    bif.pht_gnt = 1'b1;
    tick();
    chk("t6_inflight", 32'(bif.pht_wr_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_pht_wr", 32'(bif.pht_wr_en), 32'd0);
    chk("t6_rst_btb_wr", 32'(bif.btb_wr_en), 32'd0);
    chk("t6_rst_rd", 32'(bif.pht_rd_en), 32'd0);
    chk("t6_rst_bcnt", bif.branch_cnt, 32'd0);
    chk("t6_rst_mcnt", bif.mispredict_cnt, 32'd0);
    chk("t6_rst_redirect", 32'(bif.redirect_valid), 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_post_pht_wr", 32'(bif.pht_wr_en), 32'd0);
      chk("t6_post_btb_wr", 32'(bif.btb_wr_en), 32'd0);
      chk("t6_post_rd", 32'(bif.pht_rd_en), 32'd0);
    end
    chk("t6_post_bcnt", bif.branch_cnt, 32'd0);
    chk("t6_post_mcnt", bif.mispredict_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
